branch_sched: RTL and testbench

Decode-stage branch/jump scheduler for the pipelined MIPS core. It holds the IF/ID stage until the operands a control instruction needs are forwarded. It then resolves the branch condition and target, and issues a redirect to fetch over a valid/ready handshake. It also produces the link address for jal/jalr and keeps saturating performance counters readable through a select port.

---
 rtl/branch_sched.sv | 173 +++++++++++++++++
 tb/tb_branch_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sched.sv
// Decode-stage branch/jump scheduler: holds ID until operands are final,
// resolves the branch, issues a redirect to fetch, and keeps perf counters.
module branch_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rt,
    input  logic [5:0]  id_funct,
    input  logic [15:0] id_imm,
    input  logic [25:0] id_index,
    input  logic [31:0] id_pc,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rs_ready,
    input  logic        rt_ready,
    input  logic        redir_ready,
    input  logic        flush,
    input  logic        cnt_clr,
    input  logic [1:0]  cnt_sel,
    output logic        stall,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        link_valid,
    output logic [31:0] link_pc,
    output logic [31:0] cnt_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]  state;
    logic        is_beq, is_bne, is_regimm, is_bgtz, is_blez;
    logic        is_j, is_jal, is_jr, is_jalr, is_special;
    logic        is_ctrl, is_link, need_rs, need_rt, ready;
    logic        rs_eq, rs_neg, rs_zero;
    logic        taken, in_issue, resolve;
    logic [31:0] pc_plus4, pc_plus8, br_tgt, jmp_tgt, target;
    logic [31:0] cnt_res, cnt_tkn, cnt_stl, cnt_bp;
    logic [3:0]  unused_rt;

    assign unused_rt  = id_rt[4:1];

    assign is_special = id_opcode == 6'b000000;
    assign is_beq     = id_opcode == 6'b000100;
    assign is_bne     = id_opcode == 6'b000101;
    assign is_regimm  = id_opcode == 6'b000001;
    assign is_bgtz    = id_opcode == 6'b000111;
    assign is_blez    = id_opcode == 6'b000110;
    assign is_j       = id_opcode == 6'b000010;
    assign is_jal     = id_opcode == 6'b000011;
    assign is_jr      = is_special && id_funct == 6'b001000;
    assign is_jalr    = is_special && id_funct == 6'b001001;

    assign need_rt = is_beq | is_bne;
    assign need_rs = need_rt | is_regimm | is_bgtz | is_blez | is_jr | is_jalr;
    assign is_ctrl = need_rs | is_j | is_jal;
    assign is_link = is_jal | is_jalr;
    assign ready   = (!need_rs || rs_ready) && (!need_rt || rt_ready);

    assign rs_eq   = rs_val == rt_val;
    assign rs_neg  = rs_val[31];
    assign rs_zero = rs_val == 32'd0;

    assign pc_plus4 = id_pc + 32'd4;
    assign pc_plus8 = id_pc + 32'd8;
    assign br_tgt   = pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};
    assign jmp_tgt  = {pc_plus4[31:28], id_index, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = br_tgt;
        unique case (1'b1)
            is_beq:    taken = rs_eq;
            is_bne:    taken = !rs_eq;
            is_regimm: taken = id_rt[0] ? !rs_neg : rs_neg;
            is_bgtz:   taken = !rs_neg && !rs_zero;
            is_blez:   taken = rs_neg || rs_zero;
            is_j, is_jal: begin
                taken  = 1'b1;
                target = jmp_tgt;
            end
            is_jr, is_jalr: begin
                taken  = 1'b1;
                target = rs_val;
            end
            default: ;
        endcase
    end

    assign in_issue = state == S_ISSUE;
    assign resolve  = !in_issue && id_valid && is_ctrl && ready && !flush;
    assign stall    = id_valid && is_ctrl && (!ready || in_issue)
                      && !flush && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            redir_valid <= 1'b0;
            redir_pc    <= 32'd0;
            link_valid  <= 1'b0;
            link_pc     <= 32'd0;
        end else begin
            link_valid <= 1'b0;
            if (flush) begin
                state       <= S_IDLE;
                redir_valid <= 1'b0;
            end else if (in_issue) begin
                if (redir_ready) begin
                    state       <= S_IDLE;
                    redir_valid <= 1'b0;
                end
            end else if (resolve) begin
                if (taken) begin
                    state       <= S_ISSUE;
                    redir_valid <= 1'b1;
                    redir_pc    <= target;
                end else begin
                    state <= S_IDLE;
                end
                if (is_link) begin
                    link_valid <= 1'b1;
                    link_pc    <= pc_plus8;
                end
            end else if (id_valid && is_ctrl) begin
                state <= S_WAIT;
            end else begin
                state <= S_IDLE;
            end
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Clear takes priority over any increment in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_res <= 32'd0;
            cnt_tkn <= 32'd0;
            cnt_stl <= 32'd0;
            cnt_bp  <= 32'd0;
        end else if (cnt_clr) begin
            cnt_res <= 32'd0;
            cnt_tkn <= 32'd0;
            cnt_stl <= 32'd0;
            cnt_bp  <= 32'd0;
        end else begin
            if (resolve)
                cnt_res <= sat_inc(cnt_res);
            if (resolve && taken)
                cnt_tkn <= sat_inc(cnt_tkn);
            if (stall)
                cnt_stl <= sat_inc(cnt_stl);
            if (redir_valid && !redir_ready)
                cnt_bp <= sat_inc(cnt_bp);
        end
    end

    always_comb begin
        cnt_data = cnt_res;
        unique case (cnt_sel)
            2'd0: cnt_data = cnt_res;
            2'd1: cnt_data = cnt_tkn;
            2'd2: cnt_data = cnt_stl;
            2'd3: cnt_data = cnt_bp;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_branch_sched.sv
// Directed testbench for branch_sched: vector table for resolve/target
// behaviour plus hand-written multi-cycle sequences.
module tb_branch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;
    logic [25:0] id_index;
    logic [31:0] id_pc;
    logic [31:0] rs_val, rt_val;
    logic        rs_ready, rt_ready;
    logic        redir_ready, flush, cnt_clr;
    logic [1:0]  cnt_sel;
    logic        stall, redir_valid, link_valid;
    logic [31:0] redir_pc, link_pc, cnt_data;

    int checks = 0;
    int fails  = 0;

    branch_sched dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rt(id_rt), .id_funct(id_funct),
        .id_imm(id_imm), .id_index(id_index), .id_pc(id_pc),
        .rs_val(rs_val), .rt_val(rt_val),
        .rs_ready(rs_ready), .rt_ready(rt_ready),
        .redir_ready(redir_ready), .flush(flush),
        .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
        .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .link_valid(link_valid), .link_pc(link_pc), .cnt_data(cnt_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rtv;
        logic        ctrl;
        logic        tkn;
        logic        lnk;
        logic [31:0] tgt;
        logic [31:0] lpc;
    } vec_t;

    vec_t tv[18];

    function automatic vec_t mk(
        input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn,
        input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] pc,
        input logic [31:0] rs, input logic [31:0] rtv, input logic ctrl,
        input logic tkn, input logic lnk, input logic [31:0] tgt,
        input logic [31:0] lpc);
        vec_t v;
        v.op = op; v.rt = rt; v.fn = fn; v.imm = imm; v.idx = idx;
        v.pc = pc; v.rs = rs; v.rtv = rtv; v.ctrl = ctrl; v.tkn = tkn;
        v.lnk = lnk; v.tgt = tgt; v.lpc = lpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input logic [1:0] s, input logic [31:0] e,
                           input string nm);
        cnt_sel = s;
        #1;
        chk(nm, cnt_data, e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [4:0] rt,
                           input logic [5:0] fn, input logic [15:0] imm,
                           input logic [25:0] idx, input logic [31:0] pc,
                           input logic [31:0] rs, input logic [31:0] rtv,
                           input logic rsr, input logic rtr);
        id_valid = 1'b1;
        id_opcode = op; id_rt = rt; id_funct = fn; id_imm = imm;
        id_index = idx; id_pc = pc; rs_val = rs; rt_val = rtv;
        rs_ready = rsr; rt_ready = rtr;
    endtask

    int n_res, n_tkn;

    initial begin
        tv[0]  = mk(6'h04, 0, 0, 16'h0004, 0, 32'h0000_3000, 5, 5, 1, 1, 0, 32'h0000_3014, 0);
        tv[1]  = mk(6'h04, 0, 0, 16'h0004, 0, 32'h0000_3000, 5, 6, 1, 0, 0, 0, 0);
        tv[2]  = mk(6'h05, 0, 0, 16'hFFFF, 0, 32'h0000_0100, 1, 2, 1, 1, 0, 32'h0000_0100, 0);
        tv[3]  = mk(6'h05, 0, 0, 16'hFFFF, 0, 32'h0000_0100, 9, 9, 1, 0, 0, 0, 0);
        tv[4]  = mk(6'h01, 1, 0, 16'h0010, 0, 32'h0000_2000, 0, 0, 1, 1, 0, 32'h0000_2044, 0);
        tv[5]  = mk(6'h01, 0, 0, 16'h0010, 0, 32'h0000_2000, 0, 0, 1, 0, 0, 0, 0);
        tv[6]  = mk(6'h07, 0, 0, 16'h0002, 0, 32'h0000_4000, 0, 0, 1, 0, 0, 0, 0);
        tv[7]  = mk(6'h07, 0, 0, 16'h0002, 0, 32'h0000_4000, 1, 0, 1, 1, 0, 32'h0000_400C, 0);
        tv[8]  = mk(6'h06, 0, 0, 16'h8000, 0, 32'h0000_5000, 32'h8000_0000, 0, 1, 1, 0, 32'hFFFE_5004, 0);
        tv[9]  = mk(6'h06, 0, 0, 16'h8000, 0, 32'h0000_5000, 7, 0, 1, 0, 0, 0, 0);
        tv[10] = mk(6'h02, 0, 0, 0, 26'h3FF_FFFF, 32'hF000_0000, 0, 0, 1, 1, 0, 32'hFFFF_FFFC, 0);
        tv[11] = mk(6'h03, 0, 0, 0, 26'h010_0000, 32'h0040_0010, 0, 0, 1, 1, 1, 32'h0040_0000, 32'h0040_0018);
        tv[12] = mk(6'h00, 0, 6'h08, 0, 0, 32'h0000_0600, 32'h1234_5679, 0, 1, 1, 0, 32'h1234_5679, 0);
        tv[13] = mk(6'h00, 0, 6'h09, 0, 0, 32'h0000_0700, 32'h0000_8000, 0, 1, 1, 1, 32'h0000_8000, 32'h0000_0708);
        tv[14] = mk(6'h04, 0, 0, 16'h0001, 0, 32'hFFFF_FFFC, 0, 0, 1, 1, 0, 32'h0000_0004, 0);
        tv[15] = mk(6'h23, 0, 0, 16'h0004, 0, 32'h0000_0800, 0, 0, 0, 0, 0, 0, 0);
        tv[16] = mk(6'h00, 0, 6'h20, 0, 0, 32'h0000_0804, 0, 0, 0, 0, 0, 0, 0);
        tv[17] = mk(6'h07, 0, 0, 16'h0002, 0, 32'h0000_4000, 32'h8000_0000, 0, 1, 0, 0, 0, 0);

        reset = 1'b0; flush = 1'b0; cnt_clr = 1'b0; cnt_sel = 2'd0;
        redir_ready = 1'b1;
        present(6'h04, 0, 0, 16'h0004, 0, 32'h3000, 5, 5, 1'b0, 1'b0);

        // Reset state
        #12;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_rv", {31'd0, redir_valid}, 0);
        chk("rst_lv", {31'd0, link_valid}, 0);
        chk("rst_rpc", redir_pc, 0);
        chk("rst_lpc", link_pc, 0);
        for (int s = 0; s < 4; s++) chk_cnt(s[1:0], 0, "rst_cnt");
        @(negedge clk);
        reset = 1'b1;
        id_valid = 1'b0;

        // Vector table
        n_res = 0; n_tkn = 0;
        for (int i = 0; i < 18; i++) begin
            nxt();
            present(tv[i].op, tv[i].rt, tv[i].fn, tv[i].imm, tv[i].idx,
                    tv[i].pc, tv[i].rs, tv[i].rtv, 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 0);
            nxt();
            id_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_rv", i), {31'd0, redir_valid}, {31'd0, tv[i].tkn});
            if (tv[i].tkn) chk($sformatf("v%0d_rpc", i), redir_pc, tv[i].tgt);
            chk($sformatf("v%0d_lv", i), {31'd0, link_valid}, {31'd0, tv[i].lnk});
            if (tv[i].lnk) chk($sformatf("v%0d_lpc", i), link_pc, tv[i].lpc);
            nxt();
            @(negedge clk);
            chk($sformatf("v%0d_idle_rv", i), {31'd0, redir_valid}, 0);
            chk($sformatf("v%0d_idle_lv", i), {31'd0, link_valid}, 0);
            if (tv[i].ctrl) n_res++;
            if (tv[i].tkn) n_tkn++;
        end
        chk_cnt(2'd0, n_res, "tbl_cnt_res");
        chk_cnt(2'd1, n_tkn, "tbl_cnt_tkn");
        chk_cnt(2'd2, 0, "tbl_cnt_stl");
        chk_cnt(2'd3, 0, "tbl_cnt_bp");

        // bltz waiting on rs for 3 cycles
        nxt(); cnt_clr = 1'b1;
        nxt(); cnt_clr = 1'b0;
        present(6'h01, 0, 0, 16'h0008, 0, 32'h6000, 32'h8000_0000, 0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bltz_stall%0d", c), {31'd0, stall}, 1);
            nxt();
        end
        rs_ready = 1'b1;
        @(negedge clk);
        chk("bltz_res_stall", {31'd0, stall}, 0);
        nxt(); id_valid = 1'b0;
        @(negedge clk);
        chk("bltz_rv", {31'd0, redir_valid}, 1);
        chk("bltz_rpc", redir_pc, 32'h6024);
        chk_cnt(2'd2, 3, "bltz_cnt_stl");

        // Taken bne under back-pressure, jr queued behind it
        nxt(); nxt(); cnt_clr = 1'b1;
        nxt(); cnt_clr = 1'b0;
        redir_ready = 1'b0;
        present(6'h05, 0, 0, 16'h0003, 0, 32'h800, 1, 2, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_res_stall", {31'd0, stall}, 0);
        nxt(); id_valid = 1'b0;
        @(negedge clk);
        chk("bp_rv0", {31'd0, redir_valid}, 1);
        chk("bp_rpc0", redir_pc, 32'h810);
        for (int c = 1; c < 4; c++) begin
            nxt();
            if (c == 1) present(6'h00, 0, 6'h08, 0, 0, 32'h900, 32'hABC0, 0, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("bp_rv%0d", c), {31'd0, redir_valid}, 1);
            chk($sformatf("bp_rpc%0d", c), redir_pc, 32'h810);
            chk($sformatf("bp_jr_stall%0d", c), {31'd0, stall}, 1);
        end
        nxt(); redir_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_stall", {31'd0, stall}, 1);
        chk("bp_hs_rv", {31'd0, redir_valid}, 1);
        nxt();
        @(negedge clk);
        chk("jr_res_stall", {31'd0, stall}, 0);
        chk("jr_res_rv", {31'd0, redir_valid}, 0);
        nxt(); id_valid = 1'b0;
        @(negedge clk);
        chk("jr_rv", {31'd0, redir_valid}, 1);
        chk("jr_rpc", redir_pc, 32'hABC0);
        chk_cnt(2'd3, 4, "bp_cnt_bp");
        chk_cnt(2'd2, 4, "bp_cnt_stl");

        // flush during ISSUE
        nxt(); nxt();
        redir_ready = 1'b0;
        present(6'h04, 0, 0, 16'h0000, 0, 32'h900, 3, 3, 1'b1, 1'b1);
        nxt(); id_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fl_rv_pre", {31'd0, redir_valid}, 1);
        nxt(); flush = 1'b0;
        present(6'h04, 0, 0, 16'h0000, 0, 32'h900, 1, 2, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl_rv", {31'd0, redir_valid}, 0);
        chk("fl_rpc_hold", redir_pc, 32'h904);
        chk("fl_idle_stall", {31'd0, stall}, 0);
        nxt(); id_valid = 1'b0; redir_ready = 1'b1;
        @(negedge clk);
        chk("fl_nt_rv", {31'd0, redir_valid}, 0);

        // flush on a resolving jal and on a waiting beq
        nxt(); flush = 1'b1;
        present(6'h03, 0, 0, 0, 26'h5, 32'h100, 0, 0, 1'b1, 1'b1);
        nxt(); flush = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        chk("fl_jal_rv", {31'd0, redir_valid}, 0);
        chk("fl_jal_lv", {31'd0, link_valid}, 0);
        chk("fl_lpc_hold", link_pc, 32'h708);
        nxt(); flush = 1'b1;
        present(6'h04, 0, 0, 0, 0, 32'h100, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_stall", {31'd0, stall}, 0);
        nxt(); flush = 1'b0; id_valid = 1'b0;

        // Saturation of the taken counter
        force dut.cnt_tkn = 32'hFFFF_FFFF;
        nxt();
        release dut.cnt_tkn;
        present(6'h02, 0, 0, 0, 26'h40, 32'h0, 0, 0, 1'b1, 1'b1);
        nxt(); id_valid = 1'b0;
        @(negedge clk);
        chk_cnt(2'd1, 32'hFFFF_FFFF, "sat_tkn");
        nxt(); nxt();

        // Clear wins over same-cycle increment
        present(6'h02, 0, 0, 0, 26'h40, 32'h0, 0, 0, 1'b1, 1'b1);
        cnt_clr = 1'b1;
        nxt(); cnt_clr = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        chk_cnt(2'd0, 0, "clr_res");
        chk_cnt(2'd1, 0, "clr_tkn");
        nxt(); nxt();

        // Reset asserted mid-WAIT
        present(6'h04, 0, 0, 0, 0, 32'h200, 1, 1, 1'b1, 1'b0);
        @(negedge clk);
        chk("w_stall0", {31'd0, stall}, 1);
        nxt();
        @(negedge clk);
        chk("w_stall1", {31'd0, stall}, 1);
        #1 reset = 1'b0;
        #1;
        chk("mr_stall", {31'd0, stall}, 0);
        chk("mr_rv", {31'd0, redir_valid}, 0);
        chk("mr_lv", {31'd0, link_valid}, 0);
        chk("mr_rpc", redir_pc, 0);
        chk("mr_lpc", link_pc, 0);
        chk_cnt(2'd2, 0, "mr_cnt_stl");
        @(negedge clk);
        reset = 1'b1;
        id_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
